// File: rtl/ascon_dec_sequencer_if.sv
// ascon_dec_sequencer_if: host-side job/result handshake bundle for ascon_dec_sequencer.
interface ascon_dec_sequencer_if #(
    parameter int K = 128,
    parameter int L = 32,
    parameter int Y = 32
);
    logic           in_valid;
    logic           in_ready;
    logic [K-1:0]   in_key;
    logic [127:0]   in_nonce;
    logic [L-1:0]   in_ad;
    logic [Y-1:0]   in_ct;
    logic [127:0]   in_exp_tag;
    logic           out_valid;
    logic           out_ready;
    logic [Y-1:0]   out_pt;
    logic [127:0]   out_tag;
    logic           out_auth_ok;
    logic           out_err;
    modport master (
        output in_valid, in_key, in_nonce, in_ad, in_ct, in_exp_tag, out_ready,
        input  in_ready, out_valid, out_pt, out_tag, out_auth_ok, out_err
    );
    modport slave (
        input  in_valid, in_key, in_nonce, in_ad, in_ct, in_exp_tag, out_ready,
        output in_ready, out_valid, out_pt, out_tag, out_auth_ok, out_err
    );
endinterface

// File: rtl/ascon_dec_sequencer.sv
// ascon_dec_sequencer: serializes one decryption job into the bit-serial Ascon core and collects pt/tag.
// Define ASCON_TAG_CHECK_EN to compare the computed tag against the host's expected tag.
module ascon_dec_sequencer #(
    parameter int K       = 128,
    parameter int L       = 32,
    parameter int Y       = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    ascon_dec_sequencer_if.slave host,
    output logic core_rst,
    output logic core_key_sdo,
    output logic core_nonce_sdo,
    output logic core_ad_sdo,
    output logic core_ct_sdo,
    output logic core_start,
    input  logic core_ready,
    input  logic core_pt_sdi,
    input  logic core_tag_sdi
);
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, CRST, SHIFT, SETTLE, START, COLLECT, DONE} state_t;
    state_t        state, nxt;
    logic [6:0]    n;
    logic [TW-1:0] t;
    logic [K-1:0]  key;
    logic [127:0]  nonce, tag, tag_nxt;
    logic [L-1:0]  ad;
    logic [Y-1:0]  ct, pt;
    logic          err, accept, shifting, timeout;
    assign accept         = host.in_valid && host.in_ready;
    assign shifting       = !rst && state == SHIFT;
    assign timeout        = state == START && !core_ready && t == TW'(TIMEOUT);
    assign tag_nxt        = {core_tag_sdi, tag[127:1]};
    assign host.in_ready  = !rst && state == IDLE;
    assign host.out_valid = !rst && state == DONE;
    assign host.out_pt    = pt;
    assign host.out_tag   = tag;
    assign host.out_err   = err;
    assign core_rst       = rst || state == CRST;
    assign core_start     = !rst && state == START;
    // Shadow registers shift left with zero fill, so fields shorter than 128 bits trail zeros.
    assign core_key_sdo   = shifting && key[K-1];
    assign core_nonce_sdo = shifting && nonce[127];
    assign core_ad_sdo    = shifting && ad[L-1];
    assign core_ct_sdo    = shifting && ct[Y-1];
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = host.in_valid ? CRST : IDLE;
            CRST:    nxt = SHIFT;
            SHIFT:   nxt = &n ? SETTLE : SHIFT;
            SETTLE:  nxt = n[0] ? START : SETTLE;
            START:   nxt = core_ready ? COLLECT : (timeout ? DONE : START);
            COLLECT: nxt = &n ? DONE : COLLECT;
            DONE:    nxt = host.out_ready ? IDLE : DONE;
            default: nxt = IDLE;
        endcase
    end
    // n wraps 127->0 out of SHIFT, so SETTLE sees n=0,1 without a separate counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            n     <= '0;
            t     <= '0;
            key   <= '0;
            nonce <= '0;
            ad    <= '0;
            ct    <= '0;
            pt    <= '0;
            tag   <= '0;
            err   <= 1'b0;
        end else begin
            state <= nxt;
            n     <= (state == CRST || state == START) ? '0 : n + 7'd1;
            t     <= state == START ? t + TW'(1) : '0;
            if (accept) begin
                key   <= host.in_key;
                nonce <= host.in_nonce;
                ad    <= host.in_ad;
                ct    <= host.in_ct;
            end else if (state == SHIFT) begin
                key   <= key << 1;
                nonce <= nonce << 1;
                ad    <= ad << 1;
                ct    <= ct << 1;
            end
            if (state == CRST) err <= 1'b0;
            if (timeout) begin
                err <= 1'b1;
                pt  <= '0;
                tag <= '0;
            end else if (state == COLLECT) begin
                tag <= tag_nxt;
                if ({1'b0, n} < 8'(Y)) pt <= Y'({core_pt_sdi, pt} >> 1);
            end
        end
    end
`ifdef ASCON_TAG_CHECK_EN
    logic [127:0] exp_tag;
    logic         auth;
    assign host.out_auth_ok = auth;
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_tag <= '0;
            auth    <= 1'b0;
        end else begin
            if (accept) exp_tag <= host.in_exp_tag;
            if (state == CRST) auth <= 1'b0;
            else if (state == COLLECT && &n) auth <= tag_nxt == exp_tag;
        end
    end
`else
    assign host.out_auth_ok = host.out_valid && !err;
`endif
endmodule

// File: tb/tb_ascon_dec_sequencer.sv
// tb_ascon_dec_sequencer: directed jobs against a serial core stub; scoreboard checks each result.
module tb_ascon_dec_sequencer;
    localparam int TO = 16;
    typedef struct {
        int            cyc;
        logic [31:0]   pt;
        logic [127:0]  tag;
        logic          auth;
        logic          err;
    } exp_t;
    logic clk = 0, rst = 1;
    logic core_rst, core_key_sdo, core_nonce_sdo, core_ad_sdo, core_ct_sdo, core_start;
    logic core_ready = 0, core_pt_sdi = 0, core_tag_sdi = 0;
    int tests = 0, fails = 0, cyc = 0, last_done = -1;
    exp_t sb[$];
    bit seen = 0;
    int jh = -100000, jc = -1;
    bit jchk = 0;
    logic [127:0] jkey, jnonce, jtag;
    logic [31:0] jad, jct, jpt;
    logic [127:0] s_key, s_nonce;
    logic [31:0] s_ad, s_ct;
    int s_cnt;
    int r_rel, r_idx;

    ascon_dec_sequencer_if #(.K(128), .L(32), .Y(32)) host();

    ascon_dec_sequencer #(.K(128), .L(32), .Y(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .host(host),
        .core_rst(core_rst), .core_key_sdo(core_key_sdo), .core_nonce_sdo(core_nonce_sdo),
        .core_ad_sdo(core_ad_sdo), .core_ct_sdo(core_ct_sdo), .core_start(core_start),
        .core_ready(core_ready), .core_pt_sdi(core_pt_sdi), .core_tag_sdi(core_tag_sdi)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Core stub: input shift registers, ad/ct keep only their first 32 bits.
    always @(posedge clk)
        if (core_rst) begin
            s_key <= '0; s_nonce <= '0; s_ad <= '0; s_ct <= '0; s_cnt <= 0;
        end else begin
            s_key   <= {s_key[126:0], core_key_sdo};
            s_nonce <= {s_nonce[126:0], core_nonce_sdo};
            if (s_cnt < 32) begin
                s_ad <= {s_ad[30:0], core_ad_sdo};
                s_ct <= {s_ct[30:0], core_ct_sdo};
            end
            s_cnt <= s_cnt + 1;
        end

    // Core stub: ready at handshake+jc, bit n of pt/tag presented during cycle jc+1+n.
    always @(posedge clk) begin
        #1;
        r_rel = cyc - jh;
        r_idx = r_rel - jc - 1;
        core_ready   = jc >= 0 && r_rel >= jc && r_rel <= jc + 128;
        core_pt_sdi  = (jc >= 0 && r_idx >= 0 && r_idx < 32) ? jpt[r_idx] : 1'b0;
        core_tag_sdi = (jc >= 0 && r_idx >= 0 && r_idx < 128) ? jtag[r_idx] : 1'b0;
        if (jchk && r_rel == 130) begin
            chk("ser_key", s_key, jkey);
            chk("ser_nonce", s_nonce, jnonce);
            chk("ser_ad", s_ad, jad);
            chk("ser_ct", s_ct, jct);
        end
        if (jchk && r_rel == 131) chk("start_early", core_start, 0);
        if (jchk && r_rel == 132) chk("start_c132", core_start, 1);
    end

    // Monitor: every cycle of out_valid is compared against the scoreboard head.
    always @(negedge clk)
        if (host.out_valid) begin
            if (sb.size() == 0) begin
                tests++; fails++;
                $display("FAIL spurious_out_valid: got 1 expected 0 at cycle %0d", cyc);
            end else begin
                if (!seen) chk("valid_cycle", cyc, sb[0].cyc);
                seen = 1;
                chk("out_pt", host.out_pt, sb[0].pt);
                chk("out_tag", host.out_tag, sb[0].tag);
                chk("out_auth_ok", host.out_auth_ok, sb[0].auth);
                chk("out_err", host.out_err, sb[0].err);
                chk("in_ready_busy", host.in_ready, 0);
                if (host.out_ready) begin
                    void'(sb.pop_front());
                    seen = 0;
                    last_done = cyc;
                end
            end
        end

    task automatic issue(input logic [127:0] k, nn, input logic [31:0] a, c, input logic [127:0] e,
                         input logic [31:0] p, input logic [127:0] tg, input int rdy, input bit push,
                         output int h);
        exp_t x;
        @(negedge clk);
        host.in_key = k; host.in_nonce = nn; host.in_ad = a; host.in_ct = c; host.in_exp_tag = e;
        host.in_valid = 1;
        for (int i = 0; i < 1000 && !host.in_ready; i++) @(negedge clk);
        if (!host.in_ready) begin
            $display("FAIL handshake: in_ready got 0 expected 1 within 1000 cycles");
            $fatal(1, "handshake timeout");
        end
        h = cyc;
        jh = h; jc = rdy; jchk = push; jkey = k; jnonce = nn; jad = a; jct = c; jpt = p; jtag = tg;
        x.cyc = rdy >= 0 ? h + rdy + 129 : h + 132 + TO + 1;
        x.pt  = rdy >= 0 ? p : 32'h0;
        x.tag = rdy >= 0 ? tg : 128'h0;
        x.err = rdy < 0;
`ifdef ASCON_TAG_CHECK_EN
        x.auth = rdy >= 0 && e == tg;
`else
        x.auth = rdy >= 0;
`endif
        if (push) sb.push_back(x);
        @(posedge clk);
        #1 host.in_valid = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 1000 && sb.size() != 0; i++) @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d results outstanding expected 0", sb.size());
            sb.delete();
            seen = 0;
        end
    endtask

    localparam logic [127:0] KA = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] NA = 128'h101112131415161718191A1B1C1D1E1F;
    localparam logic [127:0] TA = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] TD = 128'hFEDCBA98765432100F1E2D3C4B5A6978;
    localparam logic [127:0] TE = 128'h80000000000000000000000000000001;
    localparam logic [127:0] TG = 128'h00112233445566778899AABBCCDDEEFF;

    initial begin
        int h, h2;
        host.in_valid = 0; host.out_ready = 1;
        host.in_key = '0; host.in_nonce = '0; host.in_ad = '0; host.in_ct = '0; host.in_exp_tag = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", host.in_ready, 0);
        chk("rst_out_valid", host.out_valid, 0);
        chk("rst_core_rst", core_rst, 1);
        chk("rst_core_start", core_start, 0);
        chk("rst_sdo", {core_key_sdo, core_nonce_sdo, core_ad_sdo, core_ct_sdo}, 0);
        chk("rst_out_pt", host.out_pt, 0);
        chk("rst_out_tag", host.out_tag, 0);
        chk("rst_auth_err", {host.out_auth_ok, host.out_err}, 0);
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("in_ready_after_rst", host.in_ready, 1);
        issue(KA, NA, 32'hA5A5A5A5, 32'h3C3C3C3C, TA, 32'hDEADBEEF, TA, 140, 1, h);
        drain();
        issue(KA, NA, 32'hA5A5A5A5, 32'h3C3C3C3C, TA ^ 128'h1, 32'hDEADBEEF, TA, 140, 1, h);
        drain();
        issue(KA, NA, 32'h11112222, 32'h33334444, TA, 32'hDEADBEEF, TA, -1, 1, h);
        drain();
        host.out_ready = 0;
        issue(128'hFFEEDDCCBBAA99887766554433221100, 128'h0F0E0D0C0B0A09080706050403020100,
              32'h00000001, 32'h80000000, TD, 32'h12345678, TD, 135, 1, h);
        fork
            begin
                for (int i = 0; i < 1000 && !host.out_valid; i++) @(negedge clk);
                repeat (10) @(posedge clk);
                #1 host.out_ready = 1;
            end
            issue(TE, {128{1'b1}}, 32'hFFFFFFFF, 32'h0, 128'h1, 32'h80000001, TE, 132, 1, h2);
        join
        chk("b2b_accept_cycle", h2, last_done + 1);
        drain();
        issue(KA, NA, 32'hA5A5A5A5, 32'h3C3C3C3C, TA, 32'h0, TA, -1, 0, h);
        repeat (59) @(posedge clk);
        #1 rst = 1;
        @(negedge clk);
        chk("midrst_core_rst", core_rst, 1);
        chk("midrst_in_ready", host.in_ready, 0);
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("midrst_in_ready_after", host.in_ready, 1);
        chk("midrst_cycle", cyc, h + 61);
        issue(KA, NA, 32'h5A5A5A5A, 32'hC3C3C3C3, TG, 32'hCAFEF00D, TG, 140, 1, h);
        drain();
        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ascon_dec_sequencer.md
# ascon_dec_sequencer

Job-level controller for the bit-serial Ascon decryption core. It accepts one decryption job as parallel words from a host over a valid/ready handshake and resets the core. It then shifts key, nonce, associated data and ciphertext into the core's serial inputs MSB-first, starts the core, and deserializes the plaintext and tag. Returns one result word per job to the host, with an optional tag-authentication verdict.

## Interface
Parameters:
- K, 128, key width; must equal core k
- L, 32, associated-data width; must equal core l, L ≤ 128
- Y, 32, plaintext/ciphertext width; must equal core y, Y ≤ 128
- TIMEOUT, 1024, max cycles to wait for core_ready after core_start first asserts

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  job offered
- in_ready  out  1  controller idle, can accept job
- in_key  in  K  key
- in_nonce  in  128  nonce
- in_ad  in  L  associated data
- in_ct  in  Y  ciphertext
- in_exp_tag  in  128  expected tag (used only with tag check)
- core_rst  out  1  reset to core
- core_key_sdo, core_nonce_sdo, core_ad_sdo, core_ct_sdo  out  1 each  serial data to core bit 0 of its 3-bit inputs
- core_start  out  1  decryption start to core
- core_ready  in  1  core decryption_ready
- core_pt_sdi  in  1  serial plaintext, LSB-first
- core_tag_sdi  in  1  serial tag, LSB-first
- out_valid  out  1  result available
- out_ready  in  1  host accepts result
- out_pt  out  Y  plaintext
- out_tag  out  128  computed tag
- out_auth_ok  out  1  tag matched
- out_err  out  1  core timeout

## Operation
- Host bits are captured in a single transfer: in_valid & in_ready registers in_key, in_nonce, in_ad, in_ct and in_exp_tag into shadow registers.
- FSM states: IDLE, CRST, SHIFT, SETTLE, START, COLLECT, DONE.
- IDLE:
  - in_ready=1.
  - Handshake → CRST.
- CRST, one cycle:
  - core_rst=1.
  - Bit counter n←0.
  - → SHIFT.
- SHIFT, 128 cycles (n=0..127):
  - core_key_sdo=key[K-1-n] while n<K, else 0.
  - core_nonce_sdo=nonce[127-n].
  - core_ad_sdo=ad[L-1-n] while n<L, else 0.
  - core_ct_sdo=ct[Y-1-n] while n<Y, else 0.
  - After n=127 → SETTLE.
- SETTLE, two cycles, all serial outputs 0. Guarantees the core's input counter exceeds 128 before start. → START.
- START:
  - core_start=1, held until core_ready sampled 1.
  - Timeout counter increments each START cycle.
  - core_ready → COLLECT, n←0.
  - Counter reaching TIMEOUT → DONE with out_err=1; out_pt and out_tag cleared to 0.
- COLLECT, 128 cycles:
  - Because of the core's one-cycle output register, bit n is sampled on the (n+1)-th cycle after core_ready was first seen.
  - tag[n]←core_tag_sdi.
  - pt[n]←core_pt_sdi for n<Y; later pt bits are ignored.
  - core_start deasserted.
  - After n=127 → DONE.
- DONE:
  - out_valid=1; outputs stable.
  - out_valid & out_ready → IDLE.
  - in_ready stays 0 until IDLE. Earliest next-job handshake is the cycle after the DONE handshake.
- core_rst = rst OR (state==CRST).

## Timing
- Reset values:
  - in_ready=0 during rst, 1 the cycle after.
  - out_valid=0, out_pt=0, out_tag=0, out_auth_ok=0, out_err=0.
  - core_start=0, all *_sdo=0, core_rst=1 during rst.
- Cycle numbering, handshake at cycle 0:
  - CRST at cycle 1.
  - SHIFT at cycles 2–129.
  - SETTLE at 130–131.
  - core_start rises at cycle 132.
- If core_ready is first high at cycle c: capture at c+1..c+128, out_valid at c+129.
- rst at any state, including mid-SHIFT/COLLECT: the job is dropped, FSM→IDLE next cycle, no out_valid.
- in_valid while not IDLE is ignored and not stored.
- Outputs hold indefinitely while out_ready=0.

## Configuration
- ASCON_TAG_CHECK_EN defined:
  - out_auth_ok = (captured tag == shadow exp_tag), registered on entry to DONE.
  - out_auth_ok=0 when out_err=1.
- Undefined:
  - in_exp_tag is unused and no shadow register is built.
  - out_auth_ok is tied to 1 whenever out_valid=1 and out_err=0, else 0.

## Test plan
- Serialization: key=0x000102…0F, nonce=0x101112…1F, ad=0xA5A5A5A5, ct=0x3C3C3C3C into a core stub. The stub's shifted registers must equal those values exactly at cycle 130; core_start first high at cycle 132.
- Deserialization: stub raises core_ready at cycle 140 and drives pt=0xDEADBEEF and tag=0x0123…CDEF LSB-first with the one-cycle lag. Required: out_valid at cycle 269, out_pt=0xDEADBEEF, out_tag matches.
- Tag check (macro on): exp_tag equal → out_auth_ok=1; exp_tag with bit 0 flipped → out_auth_ok=0. Macro off → 1 in both cases.
- Timeout: stub never raises core_ready, TIMEOUT=16 → out_valid at cycle 149, out_err=1, out_pt=0.
- Backpressure and back-to-back:
  - out_ready low for 10 cycles → outputs stable, in_ready=0 throughout.
  - in_valid held high → second job accepted the cycle after the DONE handshake.
- Reset mid-job: rst pulsed at cycle 60 → core_rst=1 that cycle, no out_valid, in_ready=1 at cycle 61; next job completes normally.
